avalon_streaming_fifo: RTL and testbench
========================================

# avalon_streaming_fifo

Parametrised Avalon-ST FIFO with packet framing, fill-level reporting and an optional store-and-forward mode. It sits between an Avalon-ST source and sink in the test designs, buffering up to DEPTH beats. Each beat carries DATA_W data bits plus startofpacket/endofpacket. Intended as the general buffering stage that the bus-functional models and monitors are exercised against.

## Interface
- DATA_W, 8: data width in bits, >= 1.
- DEPTH, 16: storage depth in beats; power of two, >= 2.
- ALMOST_FULL_TH, DEPTH-2: almost_full asserts when fill_level >= this value; range 1..DEPTH.
- clk  in  1  single clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- asi_valid  in  1  sink beat valid.
- asi_data  in  DATA_W  sink data.
- asi_startofpacket  in  1  first beat of packet.
- asi_endofpacket  in  1  last beat of packet.
- asi_ready  out  1  sink may accept a beat this cycle.
- aso_valid  out  1  source beat valid.
- aso_data  out  DATA_W  source data.
- aso_startofpacket  out  1  framing bit stored with the beat.
- aso_endofpacket  out  1  framing bit stored with the beat.
- aso_ready  in  1  downstream accepts the beat.
- fill_level  out  $clog2(DEPTH)+1  beats currently stored.
- almost_full  out  1  fill_level >= ALMOST_FULL_TH.

## Operation
- Storage: DEPTH x (DATA_W+2) register array, wr_ptr/rd_ptr of $clog2(DEPTH) bits wrapping modulo DEPTH, count register 0..DEPTH.
- Push = asi_valid && asi_ready; writes {sop, eop, data} at wr_ptr, wr_ptr+1.
- Pop = aso_valid && aso_ready; rd_ptr+1.
- count_next = count + push - pop; push and pop in the same cycle leave count unchanged.
- asi_ready is registered: asi_ready <= (count_next < DEPTH). No beat is ever accepted when full.
- aso_data/aso_startofpacket/aso_endofpacket drive mem[rd_ptr] combinationally. The value is undefined when aso_valid = 0.
- aso_valid = (count != 0) in cut-through mode; see Configuration.
- fill_level = count. almost_full is registered from count_next.
- Framing bits are stored verbatim; the FIFO neither checks nor repairs malformed packets.
- Reset, asserted at any time including mid-packet: count = 0, pointers = 0, asi_ready = 0, aso_valid = 0, fill_level = 0, almost_full = 0, packet counter = 0. Stored contents are discarded. Memory contents are not cleared.

## Timing
- Beat pushed at edge N: aso_valid high after edge N, so it is poppable in cycle N+1. Write-to-read latency is 1 cycle.
- After reset_n deasserts, asi_ready rises at the first clk edge.
- Full boundary: the push that makes count = DEPTH drops asi_ready after that same edge. A pop while full raises asi_ready after the popping edge. A push in that cycle is impossible because asi_ready was 0.
- Empty boundary: pop of the last beat with a simultaneous push keeps aso_valid high and presents the new beat next cycle.
- Sustained throughput: 1 beat/cycle with asi_valid = aso_ready = 1 continuous.

## Configuration
- Macro AVST_FIFO_STORE_FORWARD_EN.
- Defined (store-and-forward):
  - A pkt_count register counts stored beats with eop = 1. It increments on push of an eop beat and decrements on pop of an eop beat; both in the same cycle leave it unchanged.
  - aso_valid = (count != 0) && (pkt_count != 0 || count == DEPTH).
  - The full override prevents deadlock for packets longer than DEPTH: such packets degrade to cut-through.
- Undefined: pkt_count is absent and aso_valid = (count != 0) (cut-through).

## Test plan
- Reset, then push 0x01..0x10 with DEPTH = 16 and aso_ready = 0. Required: fill_level reaches 16, almost_full asserts at 14, and asi_ready is 0 after the 16th push edge. Then aso_ready = 1: data pops out in order 0x01..0x10.
- Continuous asi_valid = aso_ready = 1 for 100 beats. Required: 1 beat/cycle, fill_level stays at 1, data in order, no bubbles after the first cycle.
- Push while full and pop simultaneously, then drain to empty with a simultaneous push on the last pop. Required: count is correct, and aso_valid never drops at the empty crossover.
- Assert reset_n low mid-packet with 5 beats stored. Required: aso_valid, asi_ready, fill_level and almost_full are 0 immediately. After release the FIFO is empty and the first new beat is output with its own sop.
- With STORE_FORWARD_EN, push a 3-beat packet (sop on beat 1, eop on beat 3). Required: aso_valid stays 0 until the cycle after the eop push. A 20-beat packet with DEPTH = 16 starts output once count = 16.
- Without STORE_FORWARD_EN, push the same 3-beat packet. Required: beat 1 is valid one cycle after its push.

Source files
------------

// File: rtl/avalon_streaming_fifo.sv
// avalon_streaming_fifo
// Avalon-ST FIFO carrying DATA_W data bits plus startofpacket/endofpacket per
// beat, with fill-level and almost-full reporting.
// Optional feature macro: AVST_FIFO_STORE_FORWARD_EN
//   defined   -> store-and-forward: output is held until a complete packet
//                (an eop beat) is stored, or the FIFO is full.
//   undefined -> cut-through: any stored beat is presented immediately.

module avalon_streaming_fifo #(
  parameter int DATA_W         = 8,
  parameter int DEPTH          = 16,
  parameter int ALMOST_FULL_TH = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       asi_valid,
  input  logic [DATA_W-1:0]          asi_data,
  input  logic                       asi_startofpacket,
  input  logic                       asi_endofpacket,
  output logic                       asi_ready,
  output logic                       aso_valid,
  output logic [DATA_W-1:0]          aso_data,
  output logic                       aso_startofpacket,
  output logic                       aso_endofpacket,
  input  logic                       aso_ready,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic                       almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_W + 2;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_TH_C = CW'(ALMOST_FULL_TH);

  // Each entry is {sop, eop, data}
  logic [EW-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          asi_ready_q, asi_ready_d;
  logic          almost_full_q, almost_full_d;

  logic          push;
  logic          pop;
  logic [EW-1:0] rd_entry;

  assign rd_entry = mem_q[rd_ptr_q];

  // Handshakes: a push needs the registered ready, a pop the presented valid
  always_comb begin
    push = asi_valid && asi_ready_q;
    pop  = aso_valid && aso_ready;
  end

  // Next-state for pointers, occupancy and the registered status flags
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q + CW'(push) - CW'(pop);
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    // ready is computed from the post-edge count so a full FIFO never accepts
    asi_ready_d   = (count_d < DEPTH_C);
    almost_full_d = (count_d >= AF_TH_C);
  end

  // Pointer, occupancy and status registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      asi_ready_q   <= 1'b0;
      almost_full_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      asi_ready_q   <= asi_ready_d;
      almost_full_q <= almost_full_d;
    end
  end

  // Storage array; deliberately not reset, stale contents are unreachable
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {asi_startofpacket, asi_endofpacket, asi_data};
    end
  end

`ifdef AVST_FIFO_STORE_FORWARD_EN
  logic [CW-1:0] pkt_count_q, pkt_count_d;
  logic          push_eop;
  logic          pop_eop;

  // Track how many complete packets (stored eop beats) are buffered
  always_comb begin
    push_eop    = push && asi_endofpacket;
    pop_eop     = pop && rd_entry[DATA_W];
    pkt_count_d = pkt_count_q + CW'(push_eop) - CW'(pop_eop);
  end

  // Complete-packet counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_count_q <= '0;
    end else begin
      pkt_count_q <= pkt_count_d;
    end
  end

  // Hold output until a whole packet is stored; a full FIFO overrides so that
  // packets longer than DEPTH fall back to cut-through instead of deadlocking
  always_comb begin
    aso_valid = (count_q != '0) && ((pkt_count_q != '0) || (count_q == DEPTH_C));
  end
`else
  // Cut-through: any stored beat is presented
  always_comb begin
    aso_valid = (count_q != '0);
  end
`endif

  // Head entry and status to the ports
  always_comb begin
    aso_data          = rd_entry[DATA_W-1:0];
    aso_endofpacket   = rd_entry[DATA_W];
    aso_startofpacket = rd_entry[DATA_W+1];
    asi_ready         = asi_ready_q;
    fill_level        = count_q;
    almost_full       = almost_full_q;
  end

endmodule

// File: tb/tb_avalon_streaming_fifo.sv
module tb_avalon_streaming_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              asi_valid = 1'b0;
  logic [DATA_W-1:0] asi_data = '0;
  logic              asi_startofpacket = 1'b0;
  logic              asi_endofpacket = 1'b0;
  logic              asi_ready;
  logic              aso_valid;
  logic [DATA_W-1:0] aso_data;
  logic              aso_startofpacket;
  logic              aso_endofpacket;
  logic              aso_ready = 1'b0;
  logic [4:0]        fill_level;
  logic              almost_full;

  int checks = 0;
  int failures = 0;

  avalon_streaming_fifo #(
    .DATA_W(DATA_W),
    .DEPTH(DEPTH),
    .ALMOST_FULL_TH(DEPTH - 2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .asi_valid(asi_valid),
    .asi_data(asi_data),
    .asi_startofpacket(asi_startofpacket),
    .asi_endofpacket(asi_endofpacket),
    .asi_ready(asi_ready),
    .aso_valid(aso_valid),
    .aso_data(aso_data),
    .aso_startofpacket(aso_startofpacket),
    .aso_endofpacket(aso_endofpacket),
    .aso_ready(aso_ready),
    .fill_level(fill_level),
    .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic sop, input logic eop);
    asi_valid = v;
    asi_data = d;
    asi_startofpacket = sop;
    asi_endofpacket = eop;
  endtask

  initial begin
    int pi;
    int po;

    // ---------------- reset ----------------
    #2 reset_n = 1'b0;
    tick();
    tick();
    chk("rst_asi_ready", 32'(asi_ready), 0);
    chk("rst_aso_valid", 32'(aso_valid), 0);
    chk("rst_fill", 32'(fill_level), 0);
    chk("rst_af", 32'(almost_full), 0);
    reset_n = 1'b1;
    tick();
    chk("rel_asi_ready", 32'(asi_ready), 1);
    chk("rel_fill", 32'(fill_level), 0);

    // ---------------- fill 0x01..0x10, no pops ----------------
    aso_ready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 8'(i), i == 1, i == 16);
      tick();
      chk("fill_level", 32'(fill_level), 32'(i));
      chk("fill_af", 32'(almost_full), (i >= 14) ? 1 : 0);
      chk("fill_ready", 32'(asi_ready), (i < 16) ? 1 : 0);
    end
    chk("full_valid", 32'(aso_valid), 1);

    // ---------------- drain in order ----------------
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    aso_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      chk("drain_valid", 32'(aso_valid), 1);
      chk("drain_data", 32'(aso_data), 32'(i));
      tick();
      if (i == 1) chk("ready_after_pop", 32'(asi_ready), 1);
    end
    chk("drained_fill", 32'(fill_level), 0);
    chk("drained_valid", 32'(aso_valid), 0);
    chk("drained_af", 32'(almost_full), 0);

    // ---------------- streaming 100 single-beat packets ----------------
    aso_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 8'(i + 8'h20), 1'b1, 1'b1);
      tick();
      chk("stream_fill", 32'(fill_level), 1);
      chk("stream_valid", 32'(aso_valid), 1);
      chk("stream_data", 32'(aso_data), 32'(8'(i + 8'h20)));
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    chk("stream_end_fill", 32'(fill_level), 0);

    // ---------------- full boundary and empty crossover ----------------
    aso_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(8'h40 + i), 1'b1, 1'b1);
      tick();
    end
    chk("b_full_fill", 32'(fill_level), 16);
    chk("b_full_ready", 32'(asi_ready), 0);
    // offered push is blocked, pop of 0x40 proceeds
    drive(1'b1, 8'hEE, 1'b1, 1'b1);
    aso_ready = 1'b1;
    chk("b_pop_data", 32'(aso_data), 32'h40);
    tick();
    chk("b_after_fill", 32'(fill_level), 15);
    chk("b_after_ready", 32'(asi_ready), 1);
    // push 0x50 while popping 0x41
    drive(1'b1, 8'h50, 1'b1, 1'b1);
    chk("b_pp_data", 32'(aso_data), 32'h41);
    tick();
    chk("b_pp_fill", 32'(fill_level), 15);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 14; k++) begin
      chk("b_drain_data", 32'(aso_data), 32'(8'h42 + k));
      tick();
    end
    chk("b_one_fill", 32'(fill_level), 1);
    chk("b_one_data", 32'(aso_data), 32'h50);
    // last pop with simultaneous push
    drive(1'b1, 8'hAA, 1'b1, 1'b1);
    chk("b_cross_valid_pre", 32'(aso_valid), 1);
    tick();
    chk("b_cross_valid", 32'(aso_valid), 1);
    chk("b_cross_fill", 32'(fill_level), 1);
    chk("b_cross_data", 32'(aso_data), 32'hAA);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    chk("b_empty_fill", 32'(fill_level), 0);
    chk("b_empty_valid", 32'(aso_valid), 0);

    // ---------------- reset mid-packet ----------------
    aso_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'(8'h60 + i), i == 0, 1'b0);
      tick();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("mid_fill", 32'(fill_level), 5);
`ifndef AVST_FIFO_STORE_FORWARD_EN
    chk("mid_valid", 32'(aso_valid), 1);
`endif
    reset_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(aso_valid), 0);
    chk("mrst_ready", 32'(asi_ready), 0);
    chk("mrst_fill", 32'(fill_level), 0);
    chk("mrst_af", 32'(almost_full), 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("mrel_ready", 32'(asi_ready), 1);
    chk("mrel_fill", 32'(fill_level), 0);
    chk("mrel_valid", 32'(aso_valid), 0);
    drive(1'b1, 8'h77, 1'b1, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("mnew_valid", 32'(aso_valid), 1);
    chk("mnew_data", 32'(aso_data), 32'h77);
    chk("mnew_sop", 32'(aso_startofpacket), 1);
    chk("mnew_eop", 32'(aso_endofpacket), 1);
    aso_ready = 1'b1;
    tick();
    chk("mnew_empty", 32'(fill_level), 0);

    // ---------------- 3-beat packet ----------------
    aso_ready = 1'b0;
    drive(1'b1, 8'h91, 1'b1, 1'b0);
    tick();
`ifdef AVST_FIFO_STORE_FORWARD_EN
    chk("p3_b1_valid", 32'(aso_valid), 0);
`else
    chk("p3_b1_valid", 32'(aso_valid), 1);
    chk("p3_b1_data", 32'(aso_data), 32'h91);
`endif
    drive(1'b1, 8'h92, 1'b0, 1'b0);
    tick();
`ifdef AVST_FIFO_STORE_FORWARD_EN
    chk("p3_b2_valid", 32'(aso_valid), 0);
`else
    chk("p3_b2_valid", 32'(aso_valid), 1);
`endif
    drive(1'b1, 8'h93, 1'b0, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("p3_b3_valid", 32'(aso_valid), 1);
    aso_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("p3_data", 32'(aso_data), 32'(8'h91 + i));
      chk("p3_sop", 32'(aso_startofpacket), (i == 0) ? 1 : 0);
      chk("p3_eop", 32'(aso_endofpacket), (i == 2) ? 1 : 0);
      tick();
    end
    chk("p3_empty", 32'(fill_level), 0);
    chk("p3_empty_valid", 32'(aso_valid), 0);

    // ---------------- 20-beat packet, longer than DEPTH ----------------
    aso_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(i + 1), i == 0, 1'b0);
      tick();
`ifdef AVST_FIFO_STORE_FORWARD_EN
      if (i == 14) chk("p20_valid_15", 32'(aso_valid), 0);
`endif
    end
    chk("p20_full_fill", 32'(fill_level), 16);
    chk("p20_full_valid", 32'(aso_valid), 1);
    aso_ready = 1'b1;
    pi = 16;
    po = 0;
    for (int c = 0; c < 200 && po < 20; c++) begin
      drive(pi < 20, 8'(pi + 1), 1'b0, pi == 19);
      if (aso_valid) begin
        chk("p20_data", 32'(aso_data), 32'(po + 1));
        po++;
      end
      if (asi_valid && asi_ready) pi++;
      tick();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("p20_popped", 32'(po), 20);
    chk("p20_end_fill", 32'(fill_level), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
